// File: rtl/tea_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tea_decrypt
// Description : Iterative TEA block decryptor, one round per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tea_decrypt #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [63:0]  data_in,
    output logic [63:0]  data_out,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(ROUNDS) + 1;

    // Decryption walks the key schedule backwards from DELTA*ROUNDS.
    localparam logic [63:0]      c_sum_full = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0]      c_sum_init = c_sum_full[31:0];
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ROUNDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_sum;
    logic [31:0]      r_v0;
    logic [31:0]      r_v1;
    logic [31:0]      r_k0;
    logic [31:0]      r_k1;
    logic [31:0]      r_k2;
    logic [31:0]      r_k3;
    logic [63:0]      r_data_out;
    logic             r_done;

    logic [31:0]      w_v1_next;
    logic [31:0]      w_v0_next;

    function automatic logic [31:0] f_mix(
        input logic [31:0] v,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // v0 update uses the freshly computed v1, mirroring the encrypt order in reverse.
    always_comb begin
        w_v1_next = r_v1 - f_mix(r_v0, r_sum, r_k2, r_k3);
        w_v0_next = r_v0 - f_mix(w_v1_next, r_sum, r_k0, r_k1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_v0       <= '0;
            r_v1       <= '0;
            r_k0       <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_k3       <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k0    <= key[127:96];
                        r_k1    <= key[95:64];
                        r_k2    <= key[63:32];
                        r_k3    <= key[31:0];
                        r_v0    <= data_in[63:32];
                        r_v1    <= data_in[31:0];
                        r_sum   <= c_sum_init;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_v0  <= w_v0_next;
                    r_v1  <= w_v1_next;
                    r_sum <= r_sum - DELTA;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_data_out <= {w_v0_next, w_v1_next};
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out = r_data_out;
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;

endmodule
`default_nettype wire
